stream_checker: RTL and testbench



---
 rtl/stream_checker.sv | 118 +++++++++++
 tb/tb_stream_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// Pairs each observed word (in1) with an expected word (in2) and counts mismatches.
// After every `count` pairs it offers the count on out1 and updates pass; err is sticky.
module stream_checker #(
    parameter int bits  = 16,
    parameter int count = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] in1,
    input  logic            in1_stb,
    output logic            in1_ack,
    input  logic [bits-1:0] in2,
    input  logic            in2_stb,
    output logic            in2_ack,
    output logic [bits-1:0] out1,
    output logic            out1_stb,
    input  logic            out1_ack,
    output logic            pass,
    output logic            err
);
    // state    | meaning
    // IDLE     | after reset, arms in1_ack on the next edge
    // READ_IN1 | waiting for the observed word
    // READ_IN2 | waiting for the expected word
    // CHECK    | compare captured pair, update counters
    // REPORT   | holding the mismatch count on out1 until accepted
    typedef enum logic [2:0] {IDLE, READ_IN1, READ_IN2, CHECK, REPORT} state_t;

    localparam int              IW     = (count > 1) ? $clog2(count) : 1;
    localparam logic [IW-1:0]   LAST   = IW'(count - 1);
    localparam logic [bits-1:0] MM_MAX = '1;

    state_t            state;
    logic [bits-1:0]   reg_a;
    logic [bits-1:0]   reg_b;
    logic [IW-1:0]     index;
    logic [bits-1:0]   mismatch;
    logic [bits-1:0]   mismatch_next;
    logic              differ;

    // Saturating increment so a long run of failures never wraps back to a small count.
    always_comb begin
        differ        = (reg_a != reg_b);
        mismatch_next = mismatch;
        if (differ && (mismatch != MM_MAX)) begin
            mismatch_next = mismatch + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            in1_ack  <= 1'b0;
            in2_ack  <= 1'b0;
            out1_stb <= 1'b0;
            out1     <= '0;
            pass     <= 1'b0;
            err      <= 1'b0;
            index    <= '0;
            mismatch <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in1_ack <= 1'b1;
                    state   <= READ_IN1;
                end
                READ_IN1: begin
                    if (in1_stb && in1_ack) begin
                        reg_a   <= in1;
                        in1_ack <= 1'b0;
                        in2_ack <= 1'b1;
                        state   <= READ_IN2;
                    end
                end
                READ_IN2: begin
                    if (in2_stb && in2_ack) begin
                        reg_b   <= in2;
                        in2_ack <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    mismatch <= mismatch_next;
                    if (differ) begin
                        err <= 1'b1;
                    end
                    if (index == LAST) begin
                        index    <= '0;
                        out1     <= mismatch_next;
                        out1_stb <= 1'b1;
                        state    <= REPORT;
                    end else begin
                        index   <= index + 1'b1;
                        in1_ack <= 1'b1;
                        state   <= READ_IN1;
                    end
                end
                REPORT: begin
                    if (out1_stb && out1_ack) begin
                        out1_stb <= 1'b0;
                        pass     <= (mismatch == '0);
                        mismatch <= '0;
                        in1_ack  <= 1'b1;
                        state    <= READ_IN1;
                    end
                end
                default: begin
                    in1_ack  <= 1'b0;
                    in2_ack  <= 1'b0;
                    out1_stb <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: three instances (16b/4 pairs, 2b/8 pairs, 16b/1 pair)
// share one stimulus driver selected by sel; expected reports flow through a queue.
module tb_stream_checker;
    localparam int TMO = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        in1_stb = 1'b0;
    logic        in2_stb = 1'b0;
    logic        out1_ack = 1'b0;
    int          sel = 0;

    logic        a_ack1, a_ack2, a_stb, a_pass, a_err;
    logic [15:0] a_out;
    logic        b_ack1, b_ack2, b_stb, b_pass, b_err;
    logic [1:0]  b_out;
    logic        c_ack1, c_ack2, c_stb, c_pass, c_err;
    logic [15:0] c_out;

    logic        ack1, ack2, stb_o, pass_o, err_o;
    logic [15:0] out_o;

    always #5 clk = ~clk;

    stream_checker #(.bits(16), .count(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in1(in1), .in1_stb(in1_stb && sel == 0), .in1_ack(a_ack1),
        .in2(in2), .in2_stb(in2_stb && sel == 0), .in2_ack(a_ack2),
        .out1(a_out), .out1_stb(a_stb), .out1_ack(out1_ack && sel == 0),
        .pass(a_pass), .err(a_err));

    stream_checker #(.bits(2), .count(8)) u_dut_b (
        .clk(clk), .rst(rst),
        .in1(in1[1:0]), .in1_stb(in1_stb && sel == 1), .in1_ack(b_ack1),
        .in2(in2[1:0]), .in2_stb(in2_stb && sel == 1), .in2_ack(b_ack2),
        .out1(b_out), .out1_stb(b_stb), .out1_ack(out1_ack && sel == 1),
        .pass(b_pass), .err(b_err));

    stream_checker #(.bits(16), .count(1)) u_dut_c (
        .clk(clk), .rst(rst),
        .in1(in1), .in1_stb(in1_stb && sel == 2), .in1_ack(c_ack1),
        .in2(in2), .in2_stb(in2_stb && sel == 2), .in2_ack(c_ack2),
        .out1(c_out), .out1_stb(c_stb), .out1_ack(out1_ack && sel == 2),
        .pass(c_pass), .err(c_err));

    always_comb begin
        ack1 = c_ack1; ack2 = c_ack2; stb_o = c_stb; pass_o = c_pass; err_o = c_err; out_o = c_out;
        if (sel == 0) begin
            ack1 = a_ack1; ack2 = a_ack2; stb_o = a_stb; pass_o = a_pass; err_o = a_err; out_o = a_out;
        end else if (sel == 1) begin
            ack1 = b_ack1; ack2 = b_ack2; stb_o = b_stb; pass_o = b_pass; err_o = b_err;
            out_o = {14'b0, b_out};
        end
    end

    int cyc = 0;
    int n_xfer = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (stb_o && out1_ack) n_xfer <= n_xfer + 1;
    end

    int n_checks = 0;
    int n_pass = 0;
    int exp_q[$];
    int cnt, maxv, mask, pidx, mm;
    bit err_m[3];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic set_sel(input int s);
        sel  = s;
        cnt  = (s == 0) ? 4 : (s == 1) ? 8 : 1;
        maxv = (s == 1) ? 3 : 65535;
        mask = (s == 1) ? 3 : 65535;
        pidx = 0;
        mm   = 0;
    endtask

    task automatic wait_ack(input int which, input string tag);
        int n = 0;
        while (((which == 1) ? !ack1 : !ack2) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check_val(tag, n, 0);
    endtask

    task automatic send_pair(input int a, input int b, input int dly);
        in1 = 16'(a); in1_stb = 1'b1;
        if (dly == 0) begin
            in2 = 16'(b); in2_stb = 1'b1;
        end
        wait_ack(1, "in1_ack_timeout");
        @(negedge clk);
        in1_stb = 1'b0;
        if (dly > 0) begin
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check_val("in2_ack_waits", int'(ack2), 1);
                check_val("in1_ack_quiet", int'(ack1), 0);
            end
            in2 = 16'(b); in2_stb = 1'b1;
        end
        wait_ack(2, "in2_ack_timeout");
        @(negedge clk);
        in2_stb = 1'b0;
        if ((a & mask) != (b & mask)) begin
            err_m[sel] = 1'b1;
            if (mm < maxv) mm++;
        end
        pidx++;
        if (pidx == cnt) begin
            exp_q.push_back(mm);
            mm = 0;
            pidx = 0;
        end
    endtask

    task automatic get_report(input int hold, output int t_seen);
        int n = 0;
        int exp;
        while (!stb_o && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check_val("out1_stb_timeout", n, 0);
        t_seen = cyc;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check_val("out1", int'(out_o), exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("out1_stb_held", int'(stb_o), 1);
            check_val("out1_stable", int'(out_o), exp);
            check_val("in1_ack_in_report", int'(ack1), 0);
        end
        out1_ack = 1'b1;
        @(negedge clk);
        out1_ack = 1'b0;
        check_val("out1_stb_drop", int'(stb_o), 0);
        check_val("in1_ack_after_report", int'(ack1), 1);
        check_val("pass", int'(pass_o), (exp == 0) ? 1 : 0);
        check_val("err", int'(err_o), int'(err_m[sel]));
    endtask

    task automatic check_reset_outputs();
        check_val("rst_in1_ack", int'(ack1), 0);
        check_val("rst_in2_ack", int'(ack2), 0);
        check_val("rst_out1_stb", int'(stb_o), 0);
        check_val("rst_out1", int'(out_o), 0);
        check_val("rst_pass", int'(pass_o), 0);
        check_val("rst_err", int'(err_o), 0);
    endtask

    initial begin
        int t0, t_rep, x0;
        set_sel(0);
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        wait_ack(1, "first_in1_ack_timeout");
        t0 = cyc;

        // all-match run with no bubbles: report 12 cycles after first in1_ack
        send_pair(1, 1, 0);
        send_pair(0, 0, 0);
        send_pair(16'hFFFF, 16'hFFFF, 0);
        send_pair(10, 10, 0);
        get_report(0, t_rep);
        check_val("report_latency", t_rep - t0, 12);

        // two mismatches; err must rise before the report
        send_pair(1, 1, 0);
        send_pair(0, 1, 0);
        @(negedge clk);
        check_val("err_early", int'(err_o), 1);
        check_val("no_early_report", int'(stb_o), 0);
        send_pair(2, 3, 0);
        send_pair(5, 5, 0);
        get_report(0, t_rep);
        send_pair(4, 4, 0);
        send_pair(8, 8, 0);
        send_pair(9, 9, 0);
        send_pair(12, 12, 0);
        get_report(0, t_rep);

        // backpressure on in2 (pair 2) and on out1
        x0 = n_xfer;
        send_pair(3, 3, 0);
        send_pair(4, 9, 5);
        send_pair(5, 5, 0);
        send_pair(6, 6, 0);
        get_report(10, t_rep);
        @(negedge clk);
        check_val("one_report_xfer", n_xfer - x0, 1);

        // reset mid-run after 2 pairs including a mismatch
        send_pair(7, 7, 0);
        send_pair(7, 1, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        err_m[0] = 1'b0; err_m[1] = 1'b0; err_m[2] = 1'b0;
        set_sel(0);
        @(negedge clk);
        rst = 1'b1;
        send_pair(20, 20, 0);
        send_pair(21, 21, 0);
        send_pair(22, 22, 0);
        send_pair(23, 23, 0);
        get_report(0, t_rep);

        // saturation: 2-bit count, 8 mismatched pairs
        set_sel(1);
        send_pair(0, 1, 0);
        send_pair(1, 2, 0);
        send_pair(2, 3, 0);
        send_pair(3, 0, 0);
        send_pair(0, 2, 0);
        send_pair(1, 3, 0);
        send_pair(2, 0, 0);
        send_pair(3, 1, 0);
        get_report(0, t_rep);

        // count=1: every pair reports
        set_sel(2);
        send_pair(7, 7, 0);
        get_report(0, t_rep);
        send_pair(7, 8, 0);
        get_report(0, t_rep);

        check_val("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
